axis_axi4_wr_master: RTL and testbench
======================================

Name: axis_axi4_wr_master

Overview:
Parametrised AXI4 write master that drains an AXI-Stream into a circular region of memory using INCR bursts. It is the successor to the fixed 64-bit AXI4 bus shell, adding variable-length bursts, packet-boundary flush, 4KB-safe splitting, ring wrap and B-response tracking. It sits between the switch-side AXIS datapath and the DDR/HBM AXI interconnect.

Parameters:
C_M_AXI_ID_WIDTH, 1, AWID/BID width
C_M_AXI_ADDR_WIDTH, 32, address width
C_M_AXI_DATA_WIDTH, 64, AXI and AXIS data width; must be 32/64/128/256/512
C_M_AXI_BURST_LEN, 16, maximum beats per burst; power of 2, 1..256
C_BASE_ADDR, 32'h00000000, ring start; aligned to C_M_AXI_BURST_LEN*bytes-per-beat
C_REGION_BEATS, 4096, ring size in beats; multiple of C_M_AXI_BURST_LEN
C_FIFO_DEPTH, 64, data FIFO depth in beats; power of 2, at least 2*C_M_AXI_BURST_LEN

Ports:
M_AXI_ACLK  in  1  sole clock
M_AXI_ARESET  in  1  synchronous, active-high reset
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
s_axis_tdata  in  DATA  stream data
s_axis_tkeep  in  DATA/8  byte enables, forwarded to WSTRB
s_axis_tlast  in  1  packet end; forces burst close
M_AXI_AWID  out  ID  constant 0
M_AXI_AWADDR  out  ADDR  burst address
M_AXI_AWLEN  out  8  beats-1
M_AXI_AWSIZE  out  3  constant log2(DATA/8)
M_AXI_AWBURST  out  2  constant 2'b01 (INCR)
M_AXI_AWVALID  out  1
M_AXI_AWREADY  in  1
M_AXI_WDATA  out  DATA
M_AXI_WSTRB  out  DATA/8
M_AXI_WLAST  out  1
M_AXI_WVALID  out  1
M_AXI_WREADY  in  1
M_AXI_BID  in  ID  ignored
M_AXI_BRESP  in  2
M_AXI_BVALID  in  1
M_AXI_BREADY  out  1
o_beats_done  out  32  beats acknowledged with OKAY/EXOKAY; wraps modulo 2^32
o_err  out  1  sticky: a BRESP of SLVERR/DECERR was received
o_busy  out  1  high when FIFO is non-empty or a burst is outstanding

Behaviour:
- Reset: s_axis_tready=0 for the reset cycle, then follows FIFO space. AWVALID=0, WVALID=0, WLAST=0, BREADY=0, o_beats_done=0, o_err=0, o_busy=0. Write pointer returns to C_BASE_ADDR. FIFOs are emptied.
- Reset mid-burst: all state is abandoned. The interconnect must be reset alongside this block.
- Input side: data FIFO stores {tdata, tkeep}. s_axis_tready = !data_full && !len_full.
- A segment counter counts accepted beats. The segment closes on the accepted beat when any of these holds:
  - tlast=1
  - the count reaches C_M_AXI_BURST_LEN
  - the next beat would cross a 4KB address boundary
  - the next beat would reach the ring end
- On close, the segment length (1..C_M_AXI_BURST_LEN) is pushed into a length FIFO of depth C_FIFO_DEPTH. The input-side pointer advances and wraps to C_BASE_ADDR at C_BASE_ADDR + C_REGION_BEATS*bytes.
- Output FSM:
  - IDLE: when the length FIFO is non-empty, pop length L, latch AWADDR=out_ptr and AWLEN=L-1, assert AWVALID, go to ADDR.
  - ADDR: hold AW stable until AWREADY; then go to DATA.
  - DATA: WVALID = FIFO non-empty. A beat transfers on WVALID&&WREADY. WLAST is asserted on beat L. After the last beat go to RESP. W is never asserted before the AW handshake.
  - RESP: BREADY=1. On BVALID:
    - OKAY/EXOKAY: o_beats_done += L.
    - Otherwise: o_err <= 1.
    - In both cases out_ptr advances by L beats with ring wrap; go to IDLE.
- Only one burst is outstanding at a time. Back-to-back bursts have at least one IDLE cycle between them.
- A simultaneous FIFO push and pop leaves the FIFO count unchanged. A full FIFO deasserts tready; no data is ever dropped.
- The ring overwrites unconditionally; there is no consumer pointer.

Optional Feature:
Macro AXI_WR_ERR_STOP_EN.
- Defined: on an error BRESP the FSM enters a terminal HALT state.
  - AWVALID, WVALID and BREADY stay 0; s_axis_tready is held 0.
  - o_busy stays 1; only reset exits HALT.
- Undefined: the error only sets o_err, and operation continues normally.

Test Plan:
- DATA=64, BURST=16; 32 beats with no tlast; AW/W/B always ready -> two bursts: AWADDR 0x0 then 0x80, both AWLEN=15; o_beats_done=32.
- 5-beat packet with tlast on beat 5 -> one burst, AWLEN=4, WLAST on beat 5, WSTRB equals the tkeep of each beat.
- C_BASE_ADDR=0xF80, stream 32 beats -> bursts at 0xF80 (AWLEN=15) and 0x1000 (AWLEN=15); a 4KB split occurs only where the boundary falls mid-burst.
- C_REGION_BEATS=32, stream 48 beats -> third burst AWADDR = C_BASE_ADDR (ring wrap); o_beats_done=48.
- AWREADY held low for 100 cycles while streaming -> FIFO fills, tready drops after 64 beats, no beat is lost, and WDATA order matches the input.
- BRESP=2'b10 on the first burst -> o_err=1. With AXI_WR_ERR_STOP_EN defined: no further AWVALID. Without it: the second burst proceeds and o_beats_done counts only that burst.

Source files
------------

// File: rtl/axis_axi4_wr_master.sv
// AXI-Stream to AXI4 write master. Incoming beats are cut into INCR bursts,
// which are written into a circular region of memory. A burst closes on tlast,
// at the maximum burst length, before a 4KB boundary, or at the end of the ring.
// Only one burst is outstanding at a time.
// Optional feature macro: AXI_WR_ERR_STOP_EN. When it is defined, an error
// write response parks the master in HALT until reset.

module axis_axi4_wr_master_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wptr, rptr;

  // Pointer update; an extra wrap bit separates the full and empty cases.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every reader sees pre-edge values.
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the storage array is not reset. The pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[PW-1:0]] <= din;
  end

  assign dout  = mem[rptr[PW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
endmodule

module axis_axi4_wr_master #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int C_REGION_BEATS     = 4096,
  parameter int C_FIFO_DEPTH       = 64
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [31:0]                     o_beats_done,
  output logic                            o_err,
  output logic                            o_busy
);
  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int KW    = DW / 8;
  localparam int SIZE  = $clog2(KW);
  localparam int LW    = $clog2(C_M_AXI_BURST_LEN) + 1;
  localparam logic [AW:0] RING_END = {1'b0, C_BASE_ADDR} + (AW+1)'(C_REGION_BEATS * KW);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_HALT} state_t;

  state_t         state, state_next;
  logic [AW-1:0]  in_addr, out_addr, aw_addr;
  logic [LW-1:0]  seg_cnt, cur_len, beat_cnt, len_dout;
  logic [31:0]    beats_done;
  logic           err;
  logic           accept, seg_close, halted;
  logic           len_pop, data_pop, b_ok, b_err;
  logic           data_empty, data_full, len_empty, len_full;
  logic [AW:0]    in_next, out_next;
  logic [LW-1:0]  seg_len;
  logic           unused;

  assign unused = ^{M_AXI_BID, M_AXI_BRESP[0]};

`ifdef AXI_WR_ERR_STOP_EN
  assign halted = (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

  // ---------------- input side: segmenting ----------------
  assign s_axis_tready = !M_AXI_ARESET && !data_full && !len_full && !halted;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign seg_len       = seg_cnt + LW'(1);
  assign in_next       = {1'b0, in_addr} + (AW+1)'(KW);
  assign seg_close     = accept && (s_axis_tlast || seg_len == LW'(C_M_AXI_BURST_LEN) ||
                                    in_next[11:0] == 12'h000 || in_next == RING_END);

  // Input pointer and segment counter. The pointer wraps at the end of the ring.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      in_addr <= C_BASE_ADDR;
      seg_cnt <= '0;
    end else if (accept) begin
      in_addr <= (in_next == RING_END) ? C_BASE_ADDR : in_next[AW-1:0];
      seg_cnt <= seg_close ? '0 : seg_len;
    end
  end

  axis_axi4_wr_master_fifo #(.W(DW + KW), .DEPTH(C_FIFO_DEPTH)) u_data_fifo (
    .clk   (M_AXI_ACLK),
    .rst   (M_AXI_ARESET),
    .push  (accept),
    .din   ({s_axis_tdata, s_axis_tkeep}),
    .pop   (data_pop),
    .dout  ({M_AXI_WDATA, M_AXI_WSTRB}),
    .empty (data_empty),
    .full  (data_full)
  );

  axis_axi4_wr_master_fifo #(.W(LW), .DEPTH(C_FIFO_DEPTH)) u_len_fifo (
    .clk   (M_AXI_ACLK),
    .rst   (M_AXI_ARESET),
    .push  (seg_close),
    .din   (seg_len),
    .pop   (len_pop),
    .dout  (len_dout),
    .empty (len_empty),
    .full  (len_full)
  );

  // ---------------- output side: burst FSM ----------------
  // State register.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) state <= S_IDLE;
    else              state <= state_next;
  end

  // Next state and channel handshakes for the single outstanding burst.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_next    = state;
    len_pop       = 1'b0;
    data_pop      = 1'b0;
    b_ok          = 1'b0;
    b_err         = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    case (state)
      S_IDLE: if (!len_empty) begin
        len_pop    = 1'b1;
        state_next = S_ADDR;
      end
      S_ADDR: begin
        M_AXI_AWVALID = 1'b1;
        if (M_AXI_AWREADY) state_next = S_DATA;
      end
      S_DATA: begin
        M_AXI_WVALID = !data_empty;
        M_AXI_WLAST  = !data_empty && (beat_cnt == cur_len - LW'(1));
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          data_pop = 1'b1;
          if (M_AXI_WLAST) state_next = S_RESP;
        end
      end
      S_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          b_ok       = !M_AXI_BRESP[1];
          b_err      = M_AXI_BRESP[1];
          state_next = S_IDLE;
`ifdef AXI_WR_ERR_STOP_EN
          if (M_AXI_BRESP[1]) state_next = S_HALT;
`endif
        end
      end
      default: state_next = state;
    endcase
  end

  assign out_next = {1'b0, out_addr} + ((AW+1)'(cur_len) << SIZE);

  // Burst context, output pointer and completion counters.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      out_addr   <= C_BASE_ADDR;
      aw_addr    <= C_BASE_ADDR;
      cur_len    <= LW'(1);
      beat_cnt   <= '0;
      beats_done <= '0;
      err        <= 1'b0;
    end else begin
      if (len_pop) begin
        aw_addr  <= out_addr;
        cur_len  <= len_dout;
        beat_cnt <= '0;
      end
      if (data_pop) beat_cnt <= beat_cnt + LW'(1);
      if (b_ok)     beats_done <= beats_done + 32'(cur_len);
      if (b_err)    err <= 1'b1;
      if (b_ok || b_err)
        out_addr <= (out_next >= RING_END) ? C_BASE_ADDR : out_next[AW-1:0];
    end
  end

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = aw_addr;
  assign M_AXI_AWLEN   = 8'(cur_len - LW'(1));
  assign M_AXI_AWSIZE  = 3'(SIZE);
  assign M_AXI_AWBURST = 2'b01;
  assign o_beats_done  = beats_done;
  assign o_err         = err;
  assign o_busy        = !data_empty || (state != S_IDLE);
endmodule

// File: tb/tb_axis_axi4_wr_master.sv
// Directed bench for axis_axi4_wr_master. The ring is placed at 0xF80 and is
// 32 beats long, so it straddles a 4KB boundary. A small memory-side responder
// and an in-order data scoreboard run alongside the directed scenario tasks.
module tb_axis_axi4_wr_master;
  logic        clk = 1'b0;
  logic        M_AXI_ARESET = 1'b1;
  logic        s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic [0:0]  M_AXI_AWID, M_AXI_BID = '0;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST, M_AXI_BRESP = 2'b00;
  logic        M_AXI_AWVALID, M_AXI_AWREADY = 1'b1;
  logic [63:0] M_AXI_WDATA;
  logic [7:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY = 1'b1;
  logic        M_AXI_BVALID = 1'b0, M_AXI_BREADY;
  logic [31:0] o_beats_done;
  logic        o_err, o_busy;

  int n_cmp = 0, n_mis = 0;
  int n_acc = 0, aw_cnt = 0, wl_cnt = 0, b_cnt = 0, b_pending = 0, err_bursts = 0;
  int w_idx = 0;
  logic [7:0]  cur_awlen = '0;
  logic [31:0] data_ctr = 32'h100;
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic        w_last_q[$];
  logic [7:0]  w_strb_q[$];
  logic [63:0] exp_data_q[$];
  logic [7:0]  exp_strb_q[$];

  always #5 clk = ~clk;

  axis_axi4_wr_master #(
    .C_BASE_ADDR(32'h0000_0F80),
    .C_REGION_BEATS(32)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(M_AXI_ARESET),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .o_beats_done(o_beats_done), .o_err(o_err), .o_busy(o_busy)
  );

  // Bus monitor and write-data scoreboard, sampled on the falling edge.
  initial begin
    logic [63:0] ed;
    logic [7:0]  es;
    logic        el;
    forever begin
      @(negedge clk);
      if (!M_AXI_ARESET) begin
        if (M_AXI_WVALID && aw_cnt == wl_cnt) begin
          n_cmp++; n_mis++;
          $display("FAIL w_before_aw: WVALID=1 with no open address phase");
        end
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          aw_addr_q.push_back(M_AXI_AWADDR);
          aw_len_q.push_back(M_AXI_AWLEN);
          cur_awlen = M_AXI_AWLEN;
          aw_cnt++;
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          n_cmp++;
          if (exp_data_q.size() == 0) begin
            n_mis++;
            $display("FAIL w_extra: got WDATA %h, expected no beat", M_AXI_WDATA);
          end else begin
            ed = exp_data_q.pop_front();
            es = exp_strb_q.pop_front();
            el = (w_idx == int'(cur_awlen));
            if (M_AXI_WDATA !== ed || M_AXI_WSTRB !== es || M_AXI_WLAST !== el) begin
              n_mis++;
              $display("FAIL w_beat: got %h/%h/%b expected %h/%h/%b",
                       M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, ed, es, el);
            end
          end
          w_last_q.push_back(M_AXI_WLAST);
          w_strb_q.push_back(M_AXI_WSTRB);
          if (M_AXI_WLAST) begin w_idx = 0; wl_cnt++; b_pending++; end
          else w_idx++;
        end
        if (M_AXI_BVALID && M_AXI_BREADY) begin
          b_pending--;
          b_cnt++;
          if (err_bursts > 0) err_bursts--;
        end
      end
    end
  end

  // Write-response responder: one response per completed burst.
  initial begin
    forever begin
      @(posedge clk); #1;
      M_AXI_BVALID = (b_pending > 0) && !M_AXI_ARESET;
      M_AXI_BRESP  = (M_AXI_BVALID && err_bursts > 0) ? 2'b10 : 2'b00;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Presents one beat; expects to be called just after a rising edge.
  task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l;
    do begin @(negedge clk); n++; end while (!s_axis_tready && n < 2000);
    if (!s_axis_tready) begin
      n_cmp++; n_mis++;
      $display("FAIL push_timeout: tready=0 after %0d cycles, expected 1", n);
    end else begin
      exp_data_q.push_back(d);
      exp_strb_q.push_back(k);
      n_acc++;
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic send_run(input int n, input logic last_end);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      push_beat({data_ctr, ~data_ctr}, 8'hFF, last_end && (i == n - 1));
      data_ctr++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((o_busy || b_pending != 0) && n < 3000) begin @(negedge clk); n++; end
    if (o_busy || b_pending != 0) begin
      n_cmp++; n_mis++;
      $display("FAIL %s_idle_timeout: busy=%b pending=%0d, expected idle", tag, o_busy, b_pending);
    end
  endtask

  task automatic clear_logs();
    aw_addr_q.delete(); aw_len_q.delete(); w_last_q.delete(); w_strb_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (s_axis_tready !== 1'b0) begin n_mis++; $display("FAIL rst_tready: got %b expected 0", s_axis_tready); end
    @(posedge clk); #1; M_AXI_ARESET = 1'b0;
    @(negedge clk);
    n_cmp += 8;
    if (M_AXI_AWVALID !== 1'b0) begin n_mis++; $display("FAIL rst_awvalid: got %b expected 0", M_AXI_AWVALID); end
    if (M_AXI_WVALID  !== 1'b0) begin n_mis++; $display("FAIL rst_wvalid: got %b expected 0", M_AXI_WVALID); end
    if (M_AXI_WLAST   !== 1'b0) begin n_mis++; $display("FAIL rst_wlast: got %b expected 0", M_AXI_WLAST); end
    if (M_AXI_BREADY  !== 1'b0) begin n_mis++; $display("FAIL rst_bready: got %b expected 0", M_AXI_BREADY); end
    if (o_beats_done  !== 32'd0) begin n_mis++; $display("FAIL rst_beats: got %0d expected 0", o_beats_done); end
    if (o_err  !== 1'b0) begin n_mis++; $display("FAIL rst_err: got %b expected 0", o_err); end
    if (o_busy !== 1'b0) begin n_mis++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
    if (s_axis_tready !== 1'b1) begin n_mis++; $display("FAIL post_rst_tready: got %b expected 1", s_axis_tready); end
    n_cmp += 3;
    if (M_AXI_AWSIZE  !== 3'd3)  begin n_mis++; $display("FAIL awsize: got %0d expected 3", M_AXI_AWSIZE); end
    if (M_AXI_AWBURST !== 2'b01) begin n_mis++; $display("FAIL awburst: got %b expected 01", M_AXI_AWBURST); end
    if (M_AXI_AWID    !== 1'b0)  begin n_mis++; $display("FAIL awid: got %b expected 0", M_AXI_AWID); end
  endtask

  // 32 beats from 0xF80: the 4KB boundary coincides with the first burst end.
  task automatic test_full_bursts();
    logic [31:0] ea [2] = '{32'h0F80, 32'h1000};
    clear_logs();
    send_run(32, 1'b0);
    wait_idle("full");
    n_cmp++;
    if (aw_addr_q.size() != 2) begin n_mis++; $display("FAIL full_aw_count: got %0d expected 2", aw_addr_q.size()); end
    else for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (aw_addr_q[i] !== ea[i] || aw_len_q[i] !== 8'd15) begin
        n_mis++; $display("FAIL full_aw%0d: got %h/%0d expected %h/15", i, aw_addr_q[i], aw_len_q[i], ea[i]);
      end
    end
    n_cmp++;
    if (o_beats_done !== 32'd32) begin n_mis++; $display("FAIL full_beats: got %0d expected 32", o_beats_done); end
  endtask

  // Five-beat packet closed by tlast with distinct byte enables.
  task automatic test_packet();
    logic [7:0] keeps [5] = '{8'hFF, 8'h0F, 8'hF0, 8'h01, 8'h80};
    clear_logs();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      push_beat({data_ctr, ~data_ctr}, keeps[i], i == 4);
      data_ctr++;
    end
    wait_idle("pkt");
    n_cmp++;
    if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h0F80 || aw_len_q[0] !== 8'd4) begin
      n_mis++; $display("FAIL pkt_aw: got %0d bursts, first %h/%0d expected 1 burst 00000f80/4",
                        aw_addr_q.size(), aw_addr_q.size() > 0 ? aw_addr_q[0] : 32'hx,
                        aw_len_q.size() > 0 ? aw_len_q[0] : 8'hx);
    end
    n_cmp++;
    if (w_last_q.size() != 5) begin n_mis++; $display("FAIL pkt_wcount: got %0d expected 5", w_last_q.size()); end
    else for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (w_last_q[i] !== (i == 4) || w_strb_q[i] !== keeps[i]) begin
        n_mis++; $display("FAIL pkt_beat%0d: got last %b strb %h expected %b/%h", i, w_last_q[i], w_strb_q[i], i == 4, keeps[i]);
      end
    end
    n_cmp++;
    if (o_beats_done !== 32'd37) begin n_mis++; $display("FAIL pkt_beats: got %0d expected 37", o_beats_done); end
  endtask

  // From 0xFA8 the 4KB boundary falls after 11 beats, mid-burst.
  task automatic test_split_4k();
    logic [31:0] ea [2] = '{32'h0FA8, 32'h1000};
    logic [7:0]  el [2] = '{8'd10, 8'd15};
    clear_logs();
    send_run(27, 1'b0);
    wait_idle("split");
    n_cmp++;
    if (aw_addr_q.size() != 2) begin n_mis++; $display("FAIL split_aw_count: got %0d expected 2", aw_addr_q.size()); end
    else for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (aw_addr_q[i] !== ea[i] || aw_len_q[i] !== el[i]) begin
        n_mis++; $display("FAIL split_aw%0d: got %h/%0d expected %h/%0d", i, aw_addr_q[i], aw_len_q[i], ea[i], el[i]);
      end
    end
    n_cmp++;
    if (o_beats_done !== 32'd64) begin n_mis++; $display("FAIL split_beats: got %0d expected 64", o_beats_done); end
  endtask

  // 48 beats over a 32-beat ring: the third burst returns to the base.
  task automatic test_ring_wrap();
    logic [31:0] ea [3] = '{32'h0F80, 32'h1000, 32'h0F80};
    clear_logs();
    send_run(48, 1'b0);
    wait_idle("wrap");
    n_cmp++;
    if (aw_addr_q.size() != 3) begin n_mis++; $display("FAIL wrap_aw_count: got %0d expected 3", aw_addr_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (aw_addr_q[i] !== ea[i] || aw_len_q[i] !== 8'd15) begin
        n_mis++; $display("FAIL wrap_aw%0d: got %h/%0d expected %h/15", i, aw_addr_q[i], aw_len_q[i], ea[i]);
      end
    end
    n_cmp++;
    if (o_beats_done !== 32'd112) begin n_mis++; $display("FAIL wrap_beats: got %0d expected 112", o_beats_done); end
  endtask

  // AWREADY stalled: the data FIFO fills at 64 beats, and nothing is lost.
  task automatic test_backpressure();
    logic [31:0] ea [5] = '{32'h1000, 32'h0F80, 32'h1000, 32'h0F80, 32'h1000};
    int acc0;
    clear_logs();
    acc0 = n_acc;
    M_AXI_AWREADY = 1'b0;
    fork
      send_run(80, 1'b0);
      begin
        repeat (100) @(negedge clk);
        n_cmp += 3;
        if (n_acc - acc0 != 64) begin n_mis++; $display("FAIL bp_accepted: got %0d expected 64", n_acc - acc0); end
        if (s_axis_tready !== 1'b0) begin n_mis++; $display("FAIL bp_tready: got %b expected 0", s_axis_tready); end
        if (M_AXI_AWVALID !== 1'b1) begin n_mis++; $display("FAIL bp_awvalid: got %b expected 1", M_AXI_AWVALID); end
        @(posedge clk); #1;
        M_AXI_AWREADY = 1'b1;
      end
    join
    wait_idle("bp");
    n_cmp++;
    if (aw_addr_q.size() != 5) begin n_mis++; $display("FAIL bp_aw_count: got %0d expected 5", aw_addr_q.size()); end
    else for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (aw_addr_q[i] !== ea[i] || aw_len_q[i] !== 8'd15) begin
        n_mis++; $display("FAIL bp_aw%0d: got %h/%0d expected %h/15", i, aw_addr_q[i], aw_len_q[i], ea[i]);
      end
    end
    n_cmp++;
    if (o_beats_done !== 32'd192) begin n_mis++; $display("FAIL bp_beats: got %0d expected 192", o_beats_done); end
  endtask

  // SLVERR on the first burst after this point.
  task automatic test_error_resp();
    int b0, n, aw0, awv;
    clear_logs();
    err_bursts = 1;
    b0 = b_cnt;
    send_run(16, 1'b0);
    n = 0;
    while (b_cnt == b0 && n < 2000) begin @(negedge clk); n++; end
    n_cmp++;
    if (b_cnt == b0) begin n_mis++; $display("FAIL err_no_bresp: got no response, expected one"); end
`ifdef AXI_WR_ERR_STOP_EN
    aw0 = aw_cnt; awv = 0;
    repeat (50) begin @(negedge clk); if (M_AXI_AWVALID) awv++; end
    n_cmp += 5;
    if (o_err !== 1'b1) begin n_mis++; $display("FAIL err_flag: got %b expected 1", o_err); end
    if (awv != 0 || aw_cnt != aw0) begin n_mis++; $display("FAIL halt_aw: got %0d AWVALID cycles expected 0", awv); end
    if (s_axis_tready !== 1'b0) begin n_mis++; $display("FAIL halt_tready: got %b expected 0", s_axis_tready); end
    if (o_busy !== 1'b1) begin n_mis++; $display("FAIL halt_busy: got %b expected 1", o_busy); end
    if (o_beats_done !== 32'd192) begin n_mis++; $display("FAIL halt_beats: got %0d expected 192", o_beats_done); end
`else
    aw0 = 0; awv = 0;
    wait_idle("err");
    n_cmp += 2;
    if (o_err !== 1'b1) begin n_mis++; $display("FAIL err_flag: got %b expected 1", o_err); end
    if (o_beats_done !== 32'd192) begin n_mis++; $display("FAIL err_beats: got %0d expected 192", o_beats_done); end
    send_run(16, 1'b0);
    wait_idle("err2");
    n_cmp += 3;
    if (aw_addr_q.size() != 2 || aw_addr_q[0] !== 32'h0F80 || aw_addr_q[1] !== 32'h1000) begin
      n_mis++; $display("FAIL err_aw: got %0d bursts expected 2 at 00000f80,00001000", aw_addr_q.size());
    end
    if (o_beats_done !== 32'd208) begin n_mis++; $display("FAIL err2_beats: got %0d expected 208", o_beats_done); end
    if (o_err !== 1'b1) begin n_mis++; $display("FAIL err_sticky: got %b expected 1", o_err); end
    if (aw0 != 0 || awv != 0) $display("unexpected internal state");
`endif
  endtask

  initial begin
    test_reset();
    test_full_bursts();
    test_packet();
    test_split_4k();
    test_ring_wrap();
    test_backpressure();
    test_error_resp();
    n_cmp++;
    if (exp_data_q.size() != 0) begin n_mis++; $display("FAIL data_left: got %0d unwritten beats expected 0", exp_data_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
